// File: rtl/cp0_exc_seq_pkg.sv
// cp0_exc_seq_pkg: shared CP0 addresses, exception codes, Status bit indices and sequencer state encoding
package cp0_exc_seq_pkg;
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam int IE  = 0;
  localparam int EXL = 1;
  localparam logic [31:0] VECTOR = 32'h0000_0020;
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, ERET_ST, REDIR} state_t;
  function automatic logic [31:0] fwd(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                      input logic [4:0] a, input logic [31:0] cur);
    return (we && wa == a) ? wd : cur;
  endfunction
endpackage

// File: rtl/cp0_exc_seq_exc_prio.sv
// cp0_exc_seq_exc_prio: interrupt evaluation and interrupt > exception > ERET priority encoding
module cp0_exc_seq_exc_prio
  import cp0_exc_seq_pkg::*;
(
  input  logic       inst_valid,
  input  logic       exc_req,
  input  logic [4:0] exc_code,
  input  logic       eret,
  input  logic       ie,
  input  logic       exl,
  input  logic [7:0] im,
  input  logic [7:0] ip,
  output logic       take,
  output logic       is_eret,
  output logic [4:0] code
);
  logic int_req;
  assign int_req = inst_valid & ie & ~exl & |(im & ip);
  assign take    = int_req | (inst_valid & (exc_req | eret));
  assign is_eret = inst_valid & eret & ~exc_req & ~int_req;
  assign code    = int_req ? EXC_INT : exc_code;
endmodule

// File: rtl/cp0_exc_seq.sv
// cp0_exc_seq: exception/ERET sequencer driving the CP0 write port (EPC, Cause, Status, then PC redirect).
// EXC_DELAY_SLOT_EN defined: in_delay_slot_i is honoured; otherwise it is ignored.
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        in_delay_slot_i,
  input  logic        eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        cp0_exc_wr_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        pc_we_o,
  output logic [31:0] new_pc_o
);
  state_t      state, state_nx;
  logic        take, is_eret, bd, bd_q;
  logic [4:0]  code, code_q;
  logic [31:0] pc_q, sr_q, tgt_q, s_fwd, c_fwd, e_fwd;
  logic [25:0] cr_q;
  logic        unused;
`ifdef EXC_DELAY_SLOT_EN
  assign bd = in_delay_slot_i;
`else
  assign bd = 1'b0;
`endif
  assign unused = ^{c_fwd[31], c_fwd[6:2], in_delay_slot_i};
  // The T0 mtc0 lands in CP0 at the T0->T1 edge; forwarding it here gives the
  // same values a T1 sample would see while keeping later outputs register-only.
  assign s_fwd = fwd(wb_we_i, wb_waddr_i, wb_wdata_i, CP0_REG_STATUS, status_i);
  assign c_fwd = fwd(wb_we_i, wb_waddr_i, wb_wdata_i, CP0_REG_CAUSE, cause_i);
  assign e_fwd = fwd(wb_we_i, wb_waddr_i, wb_wdata_i, CP0_REG_EPC, epc_i);
  cp0_exc_seq_exc_prio u_prio (
    .inst_valid(inst_valid_i),
    .exc_req   (exc_req_i),
    .exc_code  (exc_code_i),
    .eret      (eret_i),
    .ie        (status_i[IE]),
    .exl       (status_i[EXL]),
    .im        (status_i[15:8]),
    .ip        (cause_i[15:8]),
    .take      (take),
    .is_eret   (is_eret),
    .code      (code)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      code_q <= '0;
      pc_q   <= '0;
      bd_q   <= 1'b0;
      sr_q   <= '0;
      cr_q   <= '0;
      tgt_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && take) begin
        code_q <= code;
        pc_q   <= exc_pc_i;
        bd_q   <= bd;
        sr_q   <= s_fwd;
        cr_q   <= {c_fwd[30:7], c_fwd[1:0]};
        tgt_q  <= is_eret ? e_fwd : VECTOR;
      end
    end
  end
  always_comb begin
    state_nx     = state;
    cp0_we_o     = 1'b0;
    cp0_waddr_o  = '0;
    cp0_wdata_o  = '0;
    cp0_exc_wr_o = 1'b0;
    flush_o      = 1'b0;
    busy_o       = 1'b1;
    pc_we_o      = 1'b0;
    new_pc_o     = '0;
    case (state)
      IDLE: begin
        cp0_we_o    = wb_we_i;
        cp0_waddr_o = wb_waddr_i;
        cp0_wdata_o = wb_wdata_i;
        flush_o     = take;
        busy_o      = take;
        state_nx    = take ? (is_eret ? ERET_ST : W_EPC) : IDLE;
      end
      W_EPC: begin
        cp0_we_o    = ~sr_q[EXL];
        cp0_waddr_o = CP0_REG_EPC;
        cp0_wdata_o = bd_q ? pc_q - 32'd4 : pc_q;
        state_nx    = W_CAUSE;
      end
      W_CAUSE: begin
        cp0_we_o     = 1'b1;
        cp0_waddr_o  = CP0_REG_CAUSE;
        cp0_wdata_o  = {bd_q, cr_q[25:2], code_q, cr_q[1:0]};
        cp0_exc_wr_o = 1'b1;
        state_nx     = W_STATUS;
      end
      W_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CP0_REG_STATUS;
        cp0_wdata_o = sr_q | 32'h2;
        state_nx    = REDIR;
      end
      ERET_ST: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CP0_REG_STATUS;
        cp0_wdata_o = sr_q & ~32'h2;
        state_nx    = REDIR;
      end
      REDIR: begin
        pc_we_o  = 1'b1;
        new_pc_o = tgt_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      cp0_we_o     = 1'b0;
      cp0_waddr_o  = '0;
      cp0_wdata_o  = '0;
      cp0_exc_wr_o = 1'b0;
      flush_o      = 1'b0;
      busy_o       = 1'b0;
      pc_we_o      = 1'b0;
      new_pc_o     = '0;
    end
  end
endmodule
